// File: rtl/reqack_arbiter_pkg.sv
// rtl/reqack_arbiter_pkg.sv - shared state encoding for the arbiter and its worker environment
package reqack_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WORK  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/reqack_timer.sv
// rtl/reqack_timer.sv - worker delay timer; tc flags count==DELAY
module reqack_timer #(
   parameter int CWIDTH = 10,
   parameter int DELAY  = 1023
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic en,
   output logic tc
);

   localparam logic [CWIDTH-1:0] TC_VAL = CWIDTH'(DELAY);

   logic [CWIDTH-1:0] count;

   // Holding at the terminal count keeps count from wrapping when DELAY is the max value.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && !tc) begin
         count <= count + CWIDTH'(1);
      end
   end

   assign tc = (count == TC_VAL);

endmodule

// File: rtl/reqack_arbiter.sv
// rtl/reqack_arbiter.sv - round-robin arbiter sequencing one shared timed worker
module reqack_arbiter
   import reqack_arbiter_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int CWIDTH = 10,
   parameter int DELAY  = 1023,
   localparam int IW    = $clog2(NREQ)
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] ack,
   output logic            busy,
   output logic [IW-1:0]   grant_id
);

   state_t          state, state_nx;
   logic [IW-1:0]   ptr, ptr_nx;
   logic [IW-1:0]   gid_nx;
   logic            tc;

   // First set request bit scanning ptr, ptr+1, ... wrapping at NREQ.
   function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IW-1:0]   p);
      logic [IW-1:0] pick;
      logic          found;
      int            idx;
      pick  = p;
      found = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(p) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && r[idx]) begin
            pick  = IW'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   reqack_timer #(
      .CWIDTH (CWIDTH),
      .DELAY  (DELAY)
   ) u_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (state == START),
      .en      (state == WORK),
      .tc      (tc)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= IDLE;
         ptr      <= '0;
         grant_id <= '0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         grant_id <= gid_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      gid_nx   = grant_id;
      case (state)
         IDLE: begin
            if (|req) begin
               gid_nx   = rr_pick(req, ptr);
               state_nx = START;
            end
         end
         START: state_nx = WORK;
         WORK:  if (tc) state_nx = DONE;
         DONE: begin
            // Skip past the winner so a held request cannot starve the others.
            ptr_nx   = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign ack  = (state == DONE) ? (NREQ'(1) << grant_id) : '0;

endmodule
